// File: rtl/sram22_pkg.sv
// ---------------------------------------------------------------------------
// sram22_pkg
// Shared definitions for the sram22 (512x128, 8-bit write mask) front ends:
//   - width constants of the 512x128m4w8 macro configuration
//   - arbiter state encoding
//   - client_slice(): pulls client i's field out of a two-client packed bus
// ---------------------------------------------------------------------------
package sram22_pkg;

  localparam int unsigned SRAM22_ADDR_WIDTH  = 9;
  localparam int unsigned SRAM22_DATA_WIDTH  = 128;
  localparam int unsigned SRAM22_WMASK_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,   // zero-filling the array, clients held off
    ST_RUN  = 1'b1    // serving client traffic
  } state_e;

  // Extract the width-bit field of client idx from a bus packed as
  // {client1, client0}. The bus argument is the widest client bus
  // (2*DATA_WIDTH); narrower buses are zero-extended by the caller and
  // the result is truncated by the caller to the field width.
  function automatic logic [SRAM22_DATA_WIDTH-1:0] client_slice(
    input logic [2*SRAM22_DATA_WIDTH-1:0] bus,
    input logic                           idx,
    input int unsigned                    width
  );
    logic [2*SRAM22_DATA_WIDTH-1:0] shifted;
    logic [2*SRAM22_DATA_WIDTH-1:0] keep;
    shifted = idx ? (bus >> width) : bus;
    keep    = ~({(2*SRAM22_DATA_WIDTH){1'b1}} << width);
    return SRAM22_DATA_WIDTH'(shifted & keep);
  endfunction

endpackage

// File: rtl/sram22_rr_arb2.sv
// ---------------------------------------------------------------------------
// sram22_rr_arb2
// Two-way round-robin arbiter with its pointer register.
//   clk_i   clock
//   rstb_i  synchronous active-low reset (pointer -> client 0)
//   en_i    grants are allowed only while high
//   req_i   request per client
//   gnt_o   one-hot grant, combinational from req_i/en_i and the pointer
// A lone requester always wins; on contention the pointer decides, and
// after every grant the pointer moves to the other client.
// ---------------------------------------------------------------------------
module sram22_rr_arb2 (
  input  logic       clk_i,
  input  logic       rstb_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: lone requester wins, pointer breaks ties
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Pointer next state: favour the client that was not just served
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram22_arbiter.sv
// ---------------------------------------------------------------------------
// sram22_arbiter
// Two-client round-robin front end for one single-port sram22 macro.
// After reset it optionally zero-fills the whole array, then grants one
// client access per cycle and returns read data to the issuing client one
// cycle after the accept.
//
// Ports
//   clk, rstb                 clock, synchronous active-low reset
//   req_valid/req_ready       per-client handshake (bit i = client i)
//   req_we, req_wmask,
//   req_addr, req_wdata       per-client request fields, client i in slice i
//   rsp_valid                 one-cycle read-data strobe per client
//   rsp_rdata                 shared read data (macro dout pass-through)
//   init_done                 high once client traffic is being served
//   sram_*                    macro pins; controls are combinational so the
//                             macro samples them at the next posedge
//
// Parameter widths must not exceed the sram22_pkg constants (the slice
// helper works on buses of at most 2*SRAM22_DATA_WIDTH bits).
// ---------------------------------------------------------------------------
module sram22_arbiter
  import sram22_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = SRAM22_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = SRAM22_DATA_WIDTH,
  parameter int unsigned WMASK_WIDTH    = SRAM22_WMASK_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_we,
  input  logic [2*WMASK_WIDTH-1:0] req_wmask,
  input  logic [2*ADDR_WIDTH-1:0]  req_addr,
  input  logic [2*DATA_WIDTH-1:0]  req_wdata,
  output logic [1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     init_done,
  output logic                     sram_rstb,
  output logic                     sram_ce,
  output logic                     sram_we,
  output logic [WMASK_WIDTH-1:0]   sram_wmask,
  output logic [ADDR_WIDTH-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0]    sram_din,
  input  logic [DATA_WIDTH-1:0]    sram_dout
);

  localparam int unsigned WIDE = 2 * SRAM22_DATA_WIDTH;
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
  // RAM_DEPTH-1 is the all-ones address
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [1:0]              rsp_pend_q, rsp_pend_d;   // pending read tag

  logic                    arb_en_s;
  logic [1:0]              gnt_s;
  logic                    gnt_idx_s;
  logic [WIDE-1:0]         wide_mask_s;
  logic [WIDE-1:0]         wide_addr_s;
  logic [WIDE-1:0]         wide_data_s;

  // No grants while filling or while reset is held, so nothing is accepted
  // that the macro would not see.
  assign arb_en_s  = (state_q == ST_RUN) && rstb;
  assign gnt_idx_s = gnt_s[1];

  sram22_rr_arb2 u_rr_arb (
    .clk_i  (clk),
    .rstb_i (rstb),
    .en_i   (arb_en_s),
    .req_i  (req_valid),
    .gnt_o  (gnt_s)
  );

  // Zero-extend the packed client buses to the slice helper's width
  always_comb begin
    wide_mask_s = {WIDE{1'b0}};
    wide_addr_s = {WIDE{1'b0}};
    wide_data_s = {WIDE{1'b0}};
    wide_mask_s[2*WMASK_WIDTH-1:0] = req_wmask;
    wide_addr_s[2*ADDR_WIDTH-1:0]  = req_addr;
    wide_data_s[2*DATA_WIDTH-1:0]  = req_wdata;
  end

  // State/fill sequencing and macro pin drive
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rsp_pend_d = 2'b00;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = {WMASK_WIDTH{1'b0}};
    sram_addr  = {ADDR_WIDTH{1'b0}};
    sram_din   = {DATA_WIDTH{1'b0}};
    case (state_q)
      ST_INIT: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_wmask = {WMASK_WIDTH{1'b1}};
        sram_addr  = fill_cnt_q;
        sram_din   = {DATA_WIDTH{1'b0}};
        fill_cnt_d = fill_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (fill_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (gnt_s != 2'b00) begin
          sram_ce    = 1'b1;
          sram_we    = req_we[gnt_idx_s];
          sram_wmask = WMASK_WIDTH'(client_slice(wide_mask_s, gnt_idx_s, WMASK_WIDTH));
          sram_addr  = ADDR_WIDTH'(client_slice(wide_addr_s, gnt_idx_s, ADDR_WIDTH));
          sram_din   = DATA_WIDTH'(client_slice(wide_data_s, gnt_idx_s, DATA_WIDTH));
          // Only reads come back; the tag remembers who asked
          rsp_pend_d = req_we[gnt_idx_s] ? 2'b00 : gnt_s;
        end else begin
          sram_ce    = 1'b0;
          rsp_pend_d = 2'b00;
        end
      end
      default: begin
        state_d    = RESET_STATE;
        fill_cnt_d = {ADDR_WIDTH{1'b0}};
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // State, fill counter, init flag and read tag registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= RESET_STATE;
      fill_cnt_q  <= {ADDR_WIDTH{1'b0}};
      init_done_q <= 1'b0;
      rsp_pend_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      init_done_q <= init_done_d;
      rsp_pend_q  <= rsp_pend_d;
    end
  end

  assign req_ready = gnt_s;
  // A response due while reset is asserted is dropped, not delayed
  assign rsp_valid = rsp_pend_q & {2{rstb}};
  assign rsp_rdata = sram_dout;
  assign init_done = init_done_q;
  assign sram_rstb = rstb;

endmodule

// File: tb/tb_sram22_arbiter.sv
module tb_sram22_arbiter;
  localparam int AW = 9;
  localparam int DW = 128;
  localparam int MW = 16;

  logic            clk = 1'b0;
  logic            rstb;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [2*MW-1:0] req_wmask;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, sram_din, sram_dout;
  logic            init_done, sram_rstb, sram_ce, sram_we;
  logic [MW-1:0]   sram_wmask;
  logic [AW-1:0]   sram_addr;

  always #5 clk = ~clk;

  sram22_arbiter dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_rstb(sram_rstb), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  // Behavioural macro: garbage at power-up, registered dout that holds
  // after writes and idle cycles.
  logic [DW-1:0] mem [0:511];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {16{8'hA5}};
    sram_dout = {16{8'h5A}};
    forever begin
      @(posedge clk);
      if (sram_ce) begin
        if (sram_we) begin
          for (int b = 0; b < MW; b++)
            if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] = sram_din[b*8 +: 8];
        end else begin
          sram_dout = mem[sram_addr];
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: reads accepted in cycle N are expected on rsp_* in N+1
  typedef struct packed {
    logic [1:0]    onehot;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          exp_q [$];
  logic [DW-1:0] ref_mem [0:511];

  initial begin
    exp_t          e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        chk("rsp_valid_in_reset", DW'(rsp_valid), DW'(2'b00));
        exp_q.delete();
        for (int i = 0; i < 512; i++) ref_mem[i] = {DW{1'b0}};
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_valid", DW'(rsp_valid), DW'(e.onehot));
          if (rsp_valid == e.onehot) chk("rsp_rdata", rsp_rdata, e.data);
        end else begin
          chk("rsp_valid_idle", DW'(rsp_valid), DW'(2'b00));
        end
        for (int c = 0; c < 2; c++) begin
          if (req_valid[c] && req_ready[c]) begin
            a = req_addr[c*AW +: AW];
            if (req_we[c]) begin
              for (int b = 0; b < MW; b++)
                if (req_wmask[c*MW + b]) ref_mem[a][b*8 +: 8] = req_wdata[c*DW + b*8 +: 8];
            end else begin
              e.onehot = 2'b01 << c;
              e.data   = ref_mem[a];
              exp_q.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int c, input logic [AW-1:0] addr,
                            input logic [MW-1:0] mask, input logic [DW-1:0] data);
    req_addr[c*AW +: AW]  = addr;
    req_wmask[c*MW +: MW] = mask;
    req_wdata[c*DW +: DW] = data;
  endtask

  // Entered at posedge+1 of a fill cycle with counter 0
  task automatic run_fill(input int abort_at);
    bit aborted;
    aborted = 1'b0;
    for (int i = 0; i < 512 && !aborted; i++) begin
      @(negedge clk);
      chk("fill_pins",
          DW'({sram_ce, sram_we, sram_wmask, sram_addr, req_ready, |sram_din}),
          DW'({1'b1, 1'b1, 16'hFFFF, 9'(i), 2'b00, 1'b0}));
      chk("fill_init_done", DW'(init_done), DW'(1'b0));
      if (i == abort_at) begin
        #1 rstb = 1'b0;
        tick();
        rstb = 1'b1;
        aborted = 1'b1;
      end else begin
        tick();
      end
    end
    if (!aborted) begin
      req_valid = 2'b00;
      @(negedge clk);
      chk("init_done_rise", DW'(init_done), DW'(1'b1));
    end
  endtask

  // One request that waits (bounded) for its grant
  task automatic do_req(input int c, input logic we, input logic [AW-1:0] addr,
                        input logic [MW-1:0] mask, input logic [DW-1:0] data);
    bit got;
    got = 1'b0;
    set_client(c, addr, mask, data);
    req_we[c]  = we;
    req_valid  = 2'b01 << c;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (req_ready[c]) got = 1'b1;
      else tick();
    end
    chk("grant_timeout", DW'(got), DW'(1'b1));
    tick();
    req_valid = 2'b00;
  endtask

  // Single-cycle vector with an expected ready pattern
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] we,
                             input logic [1:0] exp_rdy, input string name);
    req_valid = v;
    req_we    = we;
    @(negedge clk);
    chk(name, DW'(req_ready), DW'(exp_rdy));
    tick();
    req_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    logic [1:0] ready;
  } vec_t;
  vec_t vecs [13];

  initial begin
    // {valid, we, expected ready}; pointer is 1 on entry
    vecs[0]  = '{2'b10, 2'b00, 2'b10};
    vecs[1]  = '{2'b11, 2'b00, 2'b01};
    vecs[2]  = '{2'b11, 2'b00, 2'b10};
    vecs[3]  = '{2'b11, 2'b00, 2'b01};
    vecs[4]  = '{2'b11, 2'b00, 2'b10};
    vecs[5]  = '{2'b00, 2'b00, 2'b00};
    vecs[6]  = '{2'b10, 2'b00, 2'b10};
    vecs[7]  = '{2'b11, 2'b10, 2'b01};
    vecs[8]  = '{2'b11, 2'b10, 2'b10};
    vecs[9]  = '{2'b01, 2'b01, 2'b01};
    vecs[10] = '{2'b11, 2'b00, 2'b10};
    vecs[11] = '{2'b01, 2'b00, 2'b01};
    vecs[12] = '{2'b00, 2'b00, 2'b00};

    rstb      = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_wmask = {(2*MW){1'b0}};
    req_addr  = {(2*AW){1'b0}};
    req_wdata = {(2*DW){1'b0}};
    tick();
    @(negedge clk);
    chk("reset_init_done", DW'(init_done), DW'(1'b0));
    chk("reset_ready", DW'(req_ready), DW'(2'b00));
    chk("reset_sram_rstb", DW'(sram_rstb), DW'(1'b0));
    chk("reset_addr", DW'(sram_addr), DW'(9'h000));
    tick();
    rstb = 1'b1;
    run_fill(-1);
    tick();

    // Fill read-back of the last address
    do_req(0, 1'b0, 9'h1FF, 16'h0000, {DW{1'b0}});
    @(negedge clk);
    chk("fill_readback_valid", DW'(rsp_valid), DW'(2'b01));
    chk("fill_readback_data", rsp_rdata, {DW{1'b0}});
    tick();

    // Masked write of byte 0 only
    do_req(0, 1'b1, 9'h005, 16'h0001, {16{8'hAB}});
    do_req(0, 1'b0, 9'h005, 16'h0000, {DW{1'b0}});
    @(negedge clk);
    chk("masked_rsp_valid", DW'(rsp_valid), DW'(2'b01));
    chk("masked_rdata", rsp_rdata, 128'h0000_0000_0000_0000_0000_0000_0000_00AB);
    tick();

    // Arbitration table; client 0 writes use a zero mask
    set_client(0, 9'h010, 16'h0000, {16{8'h11}});
    set_client(1, 9'h020, 16'hFFFF, 128'hCAFE_F00D_0123_4567_89AB_CDEF_1357_9BDF);
    for (int i = 0; i < 13; i++)
      drive_cycle(vecs[i].valid, vecs[i].we, vecs[i].ready, $sformatf("table_ready_%0d", i));

    // Write by client 1, read of the same address by client 0 next cycle
    set_client(1, 9'h1FF, 16'hFFFF, 128'hDEADBEEF);
    set_client(0, 9'h1FF, 16'h0000, {DW{1'b0}});
    drive_cycle(2'b10, 2'b10, 2'b10, "wtr_write_ready");
    drive_cycle(2'b01, 2'b00, 2'b01, "wtr_read_ready");
    @(negedge clk);
    chk("wtr_rsp_valid", DW'(rsp_valid), DW'(2'b01));
    chk("wtr_rdata", rsp_rdata, 128'hDEADBEEF);
    tick();

    // Read accepted, reset in the response cycle (pointer is 1 after this)
    set_client(0, 9'h005, 16'h0000, {DW{1'b0}});
    drive_cycle(2'b01, 2'b00, 2'b01, "pend_read_ready");
    rstb = 1'b0;
    @(negedge clk);
    chk("pend_rsp_suppressed", DW'(rsp_valid), DW'(2'b00));
    tick();
    rstb      = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    run_fill(200);
    run_fill(-1);
    tick();

    // Pointer back at client 0; refill cleared previously written words
    drive_cycle(2'b11, 2'b00, 2'b01, "post_reset_ptr0");
    drive_cycle(2'b11, 2'b00, 2'b10, "post_reset_ptr1");
    tick();
    tick();
    @(negedge clk);
    chk("queue_drained", DW'(exp_q.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
